// File: rtl/tmr_monitor_pkg.sv
// Shared types and helpers for the bus voter and its per-domain fault trackers.
package tmr_monitor_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTY  = 2'd2
  } fault_state_e;

  localparam int RUN_W       = 8;
  localparam int MAX_DOMAINS = 64;

  // True when at least two bits of v are set; callers zero-extend narrower vectors.
  function automatic logic popcount_ge2(input logic [MAX_DOMAINS-1:0] v);
    logic seen_one;
    logic seen_two;
    seen_one = 1'b0;
    seen_two = 1'b0;
    for (int i = 0; i < MAX_DOMAINS; i++) begin
      if (v[i]) begin
        if (seen_one) seen_two = 1'b1;
        seen_one = 1'b1;
      end
    end
    return seen_two;
  endfunction

endpackage

// File: rtl/tmr_domain_fault_tracker.sv
// Per-domain diagnostics: sticky flag, saturating disagreement counter and
// OK/SUSPECT/FAULTY persistence FSM with its consecutive-run counter.
module tmr_domain_fault_tracker
  import tmr_monitor_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int PERSIST_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_dis,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_persist
);

  localparam logic [RUN_W-1:0] PERSIST_RUN = RUN_W'(PERSIST_CYCLES);

  fault_state_e     r_state;
  logic [RUN_W-1:0] r_run;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clear) begin
      r_state  <= ST_OK;
      r_run    <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (i_en) begin
      if (i_dis) begin
        r_sticky <= 1'b1;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_OK: begin
          if (i_dis) begin
            r_run   <= RUN_W'(1);
            r_state <= (PERSIST_CYCLES == 1) ? ST_FAULTY : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (i_dis) begin
            r_run <= r_run + RUN_W'(1);
            if (r_run + RUN_W'(1) == PERSIST_RUN) r_state <= ST_FAULTY;
          end else begin
            r_run   <= '0;
            r_state <= ST_OK;
          end
        end
        // FAULTY is absorbing; only clear or reset leaves it.
        ST_FAULTY: r_state <= ST_FAULTY;
        default: begin
          r_state <= ST_OK;
          r_run   <= '0;
        end
      endcase
    end
  end

  assign o_sticky  = r_sticky;
  assign o_err_cnt = r_cnt;
  assign o_persist = (r_state == ST_FAULTY);

endmodule

// File: rtl/tmr_bus_voter_monitor.sv
// K-modular majority voter for a WIDTH-bit bus with registered per-domain
// disagreement, multi-fault, sticky, counter and persistent-fault diagnostics.
module tmr_bus_voter_monitor
  import tmr_monitor_pkg::*;
#(
  parameter int K_MMR          = 3,
  parameter int WIDTH          = 8,
  parameter int CNT_W          = 16,
  parameter int PERSIST_CYCLES = 4
) (
  input  logic                        assert_clk_i,
  input  logic                        assert_rst_i,
  input  logic [K_MMR-1:0][WIDTH-1:0] input_i,
  input  logic                        monitor_en_i,
  input  logic                        clear_i,
  output logic [K_MMR-1:0][WIDTH-1:0] output_o,
  output logic                        mismatch_o,
  output logic [K_MMR-1:0]            mismatch_dom_o,
  output logic                        multi_fault_o,
  output logic [K_MMR-1:0]            sticky_dom_o,
  output logic [K_MMR-1:0][CNT_W-1:0] err_cnt_o,
  output logic [K_MMR-1:0]            persist_fault_o
);

  if (K_MMR < 3 || (K_MMR % 2) == 0 || K_MMR > MAX_DOMAINS) begin : g_bad_k
    $error("K_MMR must be odd, >= 3 and <= MAX_DOMAINS");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("CNT_W must be >= 2");
  end
  if (PERSIST_CYCLES < 1 || PERSIST_CYCLES > 255) begin : g_bad_persist
    $error("PERSIST_CYCLES must be in 1..255");
  end

  (* dont_touch = "true" *) logic [WIDTH-1:0] w_vote;
  logic [K_MMR-1:0] w_dis;
  logic             w_multi;

  logic [K_MMR-1:0] r_mismatch_dom;
  logic             r_mismatch;
  logic             r_multi;

  genvar gi;

  // Bitwise majority: each bit looks at one column across all domains.
  for (gi = 0; gi < WIDTH; gi++) begin : g_vote
    logic [K_MMR-1:0] w_col;
    always_comb begin
      w_col = '0;
      for (int d = 0; d < K_MMR; d++) w_col[d] = input_i[d][gi];
    end
    assign w_vote[gi] = ($countones(w_col) > (K_MMR / 2));
  end

  for (gi = 0; gi < K_MMR; gi++) begin : g_dom
    assign output_o[gi] = w_vote;
    assign w_dis[gi]    = (input_i[gi] != w_vote);

    (* dont_touch = "true" *)
    tmr_domain_fault_tracker #(
      .CNT_W         (CNT_W),
      .PERSIST_CYCLES(PERSIST_CYCLES)
    ) u_tracker (
      .i_clk    (assert_clk_i),
      .i_srst   (assert_rst_i),
      .i_clear  (clear_i),
      .i_en     (monitor_en_i),
      .i_dis    (w_dis[gi]),
      .o_sticky (sticky_dom_o[gi]),
      .o_err_cnt(err_cnt_o[gi]),
      .o_persist(persist_fault_o[gi])
    );
  end

  assign w_multi = popcount_ge2(MAX_DOMAINS'(w_dis));

  // Clear outranks the enable, so the flags still report dis during a clear.
  always_ff @(posedge assert_clk_i) begin
    if (assert_rst_i) begin
      r_mismatch_dom <= '0;
      r_mismatch     <= 1'b0;
      r_multi        <= 1'b0;
    end else if (clear_i || monitor_en_i) begin
      r_mismatch_dom <= w_dis;
      r_mismatch     <= |w_dis;
      r_multi        <= w_multi;
    end else begin
      r_mismatch_dom <= '0;
      r_mismatch     <= 1'b0;
      r_multi        <= 1'b0;
    end
  end

  assign mismatch_dom_o = r_mismatch_dom;
  assign mismatch_o     = r_mismatch;
  assign multi_fault_o  = r_multi;

endmodule

// File: tb/tb_tmr_bus_voter_monitor.sv
// Bench for tmr_bus_voter_monitor: two instances (16-bit and 2-bit counters)
// share stimulus and are compared against an abstract reference model.
module tb_tmr_bus_voter_monitor;

  localparam int K = 3;
  localparam int W = 8;
  localparam int P = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, en, clr;
  logic [K-1:0][W-1:0] din;

  logic [K-1:0][W-1:0] out_a, out_b;
  logic                mis_a, mis_b, multi_a, multi_b;
  logic [K-1:0]        mdom_a, mdom_b, sticky_a, sticky_b, pf_a, pf_b;
  logic [K-1:0][15:0]  cnt_a;
  logic [K-1:0][1:0]   cnt_b;

  tmr_bus_voter_monitor #(.K_MMR(K), .WIDTH(W), .CNT_W(16), .PERSIST_CYCLES(P)) dut_a (
    .assert_clk_i(clk), .assert_rst_i(rst), .input_i(din), .monitor_en_i(en),
    .clear_i(clr), .output_o(out_a), .mismatch_o(mis_a), .mismatch_dom_o(mdom_a),
    .multi_fault_o(multi_a), .sticky_dom_o(sticky_a), .err_cnt_o(cnt_a),
    .persist_fault_o(pf_a)
  );

  tmr_bus_voter_monitor #(.K_MMR(K), .WIDTH(W), .CNT_W(2), .PERSIST_CYCLES(P)) dut_b (
    .assert_clk_i(clk), .assert_rst_i(rst), .input_i(din), .monitor_en_i(en),
    .clear_i(clr), .output_o(out_b), .mismatch_o(mis_b), .mismatch_dom_o(mdom_b),
    .multi_fault_o(multi_b), .sticky_dom_o(sticky_b), .err_cnt_o(cnt_b),
    .persist_fault_o(pf_b)
  );

  // Reference model: unbounded disagreement counts, consecutive-run lengths.
  int           m_cnt[K];
  int           m_run[K];
  bit [K-1:0]   m_sticky, m_faulty, m_mdom;
  bit           m_mis, m_multi;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] ref_vote(input logic [K-1:0][W-1:0] v);
    logic [W-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int d = 0; d < K; d++) ones += int'(v[d][b]);
      r[b] = (2 * ones > K);
    end
    return r;
  endfunction

  function automatic logic [15:0] cap16(input int c);
    return (c > 65535) ? 16'hFFFF : 16'(c);
  endfunction

  function automatic logic [1:0] cap2(input int c);
    return (c > 3) ? 2'd3 : 2'(c);
  endfunction

  function automatic logic [79:0] exp_state();
    logic [47:0] ca;
    logic [5:0]  cb;
    for (int d = 0; d < K; d++) begin
      ca[d*16 +: 16] = cap16(m_cnt[d]);
      cb[d*2 +: 2]   = cap2(m_cnt[d]);
    end
    return {4'b0, m_mdom, m_mis, m_multi, m_sticky, m_faulty, ca,
            m_mdom, m_mis, m_multi, m_sticky, m_faulty, cb};
  endfunction

  function automatic logic [79:0] dut_state();
    return {4'b0, mdom_a, mis_a, multi_a, sticky_a, pf_a, cnt_a,
            mdom_b, mis_b, multi_b, sticky_b, pf_b, cnt_b};
  endfunction

  task automatic model_edge();
    logic [W-1:0] v;
    bit [K-1:0] dis;
    int nd;
    v  = ref_vote(din);
    nd = 0;
    for (int d = 0; d < K; d++) begin
      dis[d] = (din[d] != v);
      nd += int'(dis[d]);
    end
    if (rst) begin
      for (int d = 0; d < K; d++) begin m_cnt[d] = 0; m_run[d] = 0; end
      m_sticky = '0; m_faulty = '0; m_mdom = '0; m_mis = 0; m_multi = 0;
    end else if (clr) begin
      for (int d = 0; d < K; d++) begin m_cnt[d] = 0; m_run[d] = 0; end
      m_sticky = '0; m_faulty = '0;
      m_mdom = dis; m_mis = (nd > 0); m_multi = (nd >= 2);
    end else if (en) begin
      m_mdom = dis; m_mis = (nd > 0); m_multi = (nd >= 2);
      for (int d = 0; d < K; d++) begin
        if (dis[d]) begin
          m_cnt[d]++;
          m_sticky[d] = 1'b1;
          m_run[d]++;
        end else begin
          m_run[d] = 0;
        end
        if (m_run[d] >= P) m_faulty[d] = 1'b1;
      end
    end else begin
      m_mdom = '0; m_mis = 0; m_multi = 0;
    end
  endtask

  task automatic apply(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                       input bit e, input bit c, input bit r);
    din[0] = d0; din[1] = d1; din[2] = d2;
    en = e; clr = c; rst = r;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    $display("t=%0t in=%h_%h_%h en=%0b clr=%0b rst=%0b mdom=%b multi=%0b sticky=%b pf=%b cnt=%h",
             $time, din[2], din[1], din[0], en, clr, rst, mdom_a, multi_a, sticky_a, pf_a, cnt_a);
  endtask

  task automatic test_reset();
    apply(8'($urandom), 8'($urandom), 8'($urandom), 1, 0, 1);
    tick();
    tick();
    if (dut_state() !== exp_state()) begin
      $display("FAIL reset_state got=%h want=%h", dut_state(), exp_state()); errors++;
    end
    checks++;
    if (sticky_a !== 3'b0 || pf_a !== 3'b0 || cnt_a !== 48'h0 || mis_a !== 1'b0) begin
      $display("FAIL reset_zero sticky=%b pf=%b cnt=%h mis=%b want all zero", sticky_a, pf_a, cnt_a, mis_a);
      errors++;
    end
    checks++;
  endtask

  task automatic test_agree();
    for (int i = 0; i < 10; i++) begin
      apply(8'hA5, 8'hA5, 8'hA5, 1, 0, 0);
      if (out_a !== {3{8'hA5}} || out_b !== {3{8'hA5}}) begin
        $display("FAIL agree_vote got=%h want=%h", out_a, {3{8'hA5}}); errors++;
      end
      checks++;
      tick();
      if (dut_state() !== exp_state() || cnt_a !== 48'h0 || mis_a !== 1'b0) begin
        $display("FAIL agree_state got=%h want=%h", dut_state(), exp_state()); errors++;
      end
      checks++;
    end
  endtask

  task automatic test_single_glitch();
    apply(8'hA5, 8'hA4, 8'hA5, 1, 0, 0);
    if (out_a !== {3{8'hA5}}) begin
      $display("FAIL glitch_vote got=%h want=%h", out_a, {3{8'hA5}}); errors++;
    end
    checks++;
    tick();
    if (mdom_a !== 3'b010 || mis_a !== 1'b1 || cnt_a[1] !== 16'd1 || sticky_a[1] !== 1'b1) begin
      $display("FAIL glitch_flags mdom=%b mis=%b cnt1=%0d sticky=%b want 010/1/1/x1x",
               mdom_a, mis_a, cnt_a[1], sticky_a);
      errors++;
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      apply(8'hA5, 8'hA5, 8'hA5, 1, 0, 0);
      tick();
    end
    if (pf_a !== 3'b000 || mdom_a !== 3'b000 || dut_state() !== exp_state()) begin
      $display("FAIL glitch_recover pf=%b mdom=%b got=%h want=%h", pf_a, mdom_a, dut_state(), exp_state());
      errors++;
    end
    checks++;
  endtask

  task automatic test_persist();
    apply(8'hA5, 8'hA5, 8'hA5, 1, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(8'hA5, 8'hA5, 8'h5A, 1, 0, 0);
      tick();
    end
    apply(8'hA5, 8'hA5, 8'hA5, 1, 0, 0);
    tick();
    if (pf_a[2] !== 1'b0 || dut_state() !== exp_state()) begin
      $display("FAIL persist_3cyc pf=%b want 000 got=%h want=%h", pf_a, dut_state(), exp_state());
      errors++;
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      apply(8'hA5, 8'hA5, 8'h5A, 1, 0, 0);
      tick();
      if (pf_a[2] !== (i == 3)) begin
        $display("FAIL persist_4cyc step=%0d pf2=%b want %0b", i, pf_a[2], (i == 3)); errors++;
      end
      checks++;
    end
    for (int i = 0; i < 2; i++) begin
      apply(8'hA5, 8'hA5, 8'hA5, 1, 0, 0);
      tick();
    end
    if (pf_a !== 3'b100 || dut_state() !== exp_state()) begin
      $display("FAIL persist_hold pf=%b want 100 got=%h want=%h", pf_a, dut_state(), exp_state());
      errors++;
    end
    checks++;
  endtask

  task automatic test_multi();
    apply(8'hA4, 8'hA5, 8'h25, 1, 0, 0);
    if (out_a !== {3{8'hA5}}) begin
      $display("FAIL multi_vote got=%h want=%h", out_a, {3{8'hA5}}); errors++;
    end
    checks++;
    tick();
    if (multi_a !== 1'b1 || mdom_a !== 3'b101 || dut_state() !== exp_state()) begin
      $display("FAIL multi_flags multi=%b mdom=%b want 1/101", multi_a, mdom_a); errors++;
    end
    checks++;
  endtask

  task automatic test_saturate();
    logic [1:0] want_b;
    apply(8'hA5, 8'hA5, 8'hA5, 1, 1, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(8'h5A, 8'hA5, 8'hA5, 1, 0, 0);
      tick();
      want_b = (i >= 2) ? 2'd3 : 2'(i + 1);
      if (cnt_b[0] !== want_b || cnt_a[0] !== 16'(i + 1)) begin
        $display("FAIL saturate step=%0d cnt_b0=%0d want %0d cnt_a0=%0d want %0d",
                 i, cnt_b[0], want_b, cnt_a[0], i + 1);
        errors++;
      end
      checks++;
    end
  endtask

  task automatic test_clear_enable_reset();
    for (int i = 0; i < 2; i++) begin
      apply(8'h5A, 8'hA5, 8'hA5, 1, 0, 0);
      tick();
    end
    apply(8'h5A, 8'hA5, 8'hA5, 1, 1, 0);
    tick();
    if (cnt_a[0] !== 16'd0 || sticky_a !== 3'b0 || pf_a !== 3'b0 || mdom_a !== 3'b001 || mis_a !== 1'b1) begin
      $display("FAIL clear_active cnt0=%0d sticky=%b pf=%b mdom=%b mis=%b want 0/000/000/001/1",
               cnt_a[0], sticky_a, pf_a, mdom_a, mis_a);
      errors++;
    end
    checks++;
    apply(8'h5A, 8'hA5, 8'hA5, 1, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(8'h5A, 8'hA5, 8'hA5, 0, 0, 0);
      tick();
    end
    if (cnt_a[0] !== 16'd1 || mis_a !== 1'b0 || mdom_a !== 3'b0 || dut_state() !== exp_state()) begin
      $display("FAIL enable_freeze cnt0=%0d mis=%b mdom=%b want 1/0/000", cnt_a[0], mis_a, mdom_a);
      errors++;
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      apply(8'h5A, 8'hA5, 8'hA5, 1, 0, 0);
      tick();
    end
    apply(8'h5A, 8'hA5, 8'hA5, 1, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(8'h5A, 8'hA5, 8'hA5, 1, 0, 0);
      tick();
    end
    if (pf_a[0] !== 1'b0 || cnt_a[0] !== 16'd3 || dut_state() !== exp_state()) begin
      $display("FAIL reset_mid_suspect pf0=%b cnt0=%0d want 0/3", pf_a[0], cnt_a[0]); errors++;
    end
    checks++;
  endtask

  task automatic test_random();
    logic [W-1:0] base, v;
    logic [K-1:0][W-1:0] d;
    int bad_dom;
    bad_dom = 0;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) bad_dom = int'($urandom_range(0, K - 1));
      base = 8'($urandom);
      for (int k = 0; k < K; k++) begin
        d[k] = base;
        if ((k == bad_dom && $urandom_range(0, 9) < 7) || $urandom_range(0, 7) == 0)
          d[k] = base ^ (8'd1 << $urandom_range(0, W - 1));
      end
      if ($urandom_range(0, 9) == 0) d[1] = d[0];
      apply(d[0], d[1], d[2], $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 99) == 0);
      v = ref_vote(din);
      if (out_a !== {3{v}} || out_b !== {3{v}}) begin
        $display("FAIL random_vote n=%0d got=%h want=%h", n, out_a, {3{v}}); errors++;
      end
      checks++;
      tick();
      if (dut_state() !== exp_state()) begin
        $display("FAIL random_state n=%0d got=%h want=%h", n, dut_state(), exp_state()); errors++;
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; din = '0;
    test_reset();
    test_agree();
    test_single_glitch();
    test_persist();
    test_multi();
    test_saturate();
    test_clear_enable_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_bus_voter_monitor.md
Name: tmr_bus_voter_monitor

Overview:
- Parametrised successor to the single-bit K-modular voter.
- Votes a WIDTH-bit bus replicated K_MMR times and drives K_MMR identical voted copies combinationally.
- Adds registered per-domain fault diagnostics: disagreement flags, multi-fault detection, sticky flags, saturating error counters and a per-domain persistent-fault state machine.
- Sits at TMR register-bank and FSM-state boundaries; feeds slow-control status registers.

Parameters:
- K_MMR, 3, number of redundant domains; odd, >=3 (elaboration error otherwise).
- WIDTH, 8, bus width per domain; >=1.
- CNT_W, 16, width of each per-domain saturating error counter; >=2.
- PERSIST_CYCLES, 4, consecutive disagreeing cycles that declare a domain FAULTY; 1..255.

Ports:
- assert_clk_i  in  1  clock for all diagnostic registers.
- assert_rst_i  in  1  reset, synchronous, active-high.
- input_i  in  [K_MMR-1:0][WIDTH-1:0]  replicated bus; DONT_TOUCH.
- monitor_en_i  in  1  diagnostics enable; voting is unaffected.
- clear_i  in  1  synchronous clear of counters, sticky flags and FSMs.
- output_o  out  [K_MMR-1:0][WIDTH-1:0]  voted bus, one copy per domain; DONT_TOUCH.
- mismatch_o  out  1  registered OR of mismatch_dom_o.
- mismatch_dom_o  out  [K_MMR-1:0]  registered: domain d differed from the vote.
- multi_fault_o  out  1  registered: two or more domains disagreed in the same cycle.
- sticky_dom_o  out  [K_MMR-1:0]  set on disagreement, held until clear_i.
- err_cnt_o  out  [K_MMR-1:0][CNT_W-1:0]  per-domain count of disagreeing cycles.
- persist_fault_o  out  [K_MMR-1:0]  domain FSM is in FAULTY.

Behaviour:
- Vote, per bit b: output_o[k][b] = 1 iff more than K_MMR/2 domains hold 1. Purely combinational, 0 cycles latency, identical for every k. Independent of reset and monitor_en_i.
- dis[d] (combinational) = (input_i[d] != voted value), compared over the full WIDTH.
- Diagnostic registers all update on the assert_clk_i rising edge. Priority order: assert_rst_i > clear_i > monitor_en_i.
- Reset: every output register goes to 0, all FSMs go to OK, and run counters go to 0.
- clear_i=1:
  - counters, sticky flags, run counters and FSMs go to their reset values;
  - mismatch_dom_o, mismatch_o and multi_fault_o still register the current dis;
  - disagreements in the clear cycle are not counted and do not set sticky flags.
- monitor_en_i=0: counters, sticky flags and FSMs hold; mismatch_dom_o, mismatch_o and multi_fault_o are forced to 0 on the next edge.
- monitor_en_i=1:
  - mismatch_dom_o <= dis (1-cycle latency); mismatch_o <= |dis; multi_fault_o <= popcount(dis) >= 2;
  - sticky_dom_o[d] |= dis[d];
  - err_cnt_o[d] increments when dis[d]=1 and saturates at 2^CNT_W-1 (no wrap).
- Per-domain FSM (states OK, SUSPECT, FAULTY) with an 8-bit run counter:
  - OK: if dis, run=1 and go to SUSPECT (or straight to FAULTY if PERSIST_CYCLES=1); otherwise stay.
  - SUSPECT: if dis, run+1; go to FAULTY when run+1 == PERSIST_CYCLES. If no dis, run=0 and go to OK.
  - FAULTY: absorbing; only clear_i or reset returns it to OK. Counting continues in FAULTY.
  - persist_fault_o[d] = (state==FAULTY), registered.
- With K_MMR=3, two domains failing identically outvote the good one. multi_fault_o is the only indication; the vote itself is not corrected.
- Mid-operation reset: takes effect on the same edge and discards the in-progress run count.

Decomposition:
- Package tmr_monitor_pkg:
  - fsm state enum (OK, SUSPECT, FAULTY);
  - constant RUN_W=8;
  - function popcount_ge2.
- One sub-module, tmr_domain_fault_tracker, instantiated K_MMR times in a generate loop, DONT_TOUCH. It holds the FSM, run counter, sticky flag and saturating counter for one domain.
- The top level holds the vote, dis compare and aggregate flags.

Test Plan:
- K=3, WIDTH=8, all domains 0xA5 for 10 cycles -> output_o all 0xA5; all diagnostic outputs 0; err_cnt 0.
- Domain 1=0xA4 for 1 cycle, others 0xA5:
  - output_o=0xA5 the same cycle;
  - next edge: mismatch_dom_o=3'b010 and mismatch_o=1;
  - err_cnt[1]=1, sticky[1]=1;
  - persist_fault_o stays 0 after the domain returns to agreement.
- Domain 2 disagrees for exactly 4 consecutive cycles (PERSIST_CYCLES=4) -> persist_fault_o[2]=1 after the 4th edge and stays set after recovery. Same stimulus for 3 cycles -> 0.
- Domains 0 and 2 carry different single-bit errors in one cycle -> multi_fault_o=1 next edge; mismatch_dom_o=3'b101.
- CNT_W=2, domain 0 disagrees for 5 cycles -> err_cnt[0] reads 1,2,3,3,3.
- clear_i asserted during an active disagreement:
  - counters, sticky flags and FSMs read 0/OK;
  - mismatch_dom_o still reflects dis;
  - monitor_en_i=0 freezes counters and zeroes mismatch_o;
  - assert_rst_i mid-SUSPECT returns the FSM to OK.
